// File: rtl/decode_alu_pipe_pkg.sv
// Shared definitions for the RV32I ALU decode stage.
//   - ALU operation codes carried on out_alu_control (ALU_NOP marks "no operation")
//   - Major opcodes for register-register (OP_R) and register-immediate (OP_I) ALU forms
//   - funct7 and funct3 field values used to select the ALU operation
//   - dec_t: the control fields produced by the combinational decoder
package decode_alu_pipe_pkg;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_XOR  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [4:0] alu_control;
    logic       illegal;
    logic       use_imm;
    logic       is_r;
  } dec_t;

endpackage

// File: rtl/decode_alu_pipe_scoreboard.sv
// alu_scoreboard: one busy bit per architectural register, tracking
// destinations issued but not yet written back.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 clears every busy bit (writeback in the same cycle is moot)
//   check_en              a candidate instruction is present (in_valid)
//   rs1/rs1_used          first source index and whether it is read
//   rs2/rs2_used          second source index and whether it is read
//   set_en/set_rd         mark set_rd busy (accepted legal instruction, rd != 0)
//   wb_valid/wb_rd        writeback retiring wb_rd
//   hazard                candidate reads a register still in flight
module alu_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             check_en,
  input  logic [REG_W-1:0] rs1,
  input  logic             rs1_used,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs2_used,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  output logic             hazard
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_eff;

  // A writeback landing this cycle already frees its register for the
  // hazard check, so a dependent can issue in the retiring cycle.
  always_comb begin
    busy_eff = busy_q;
    if (wb_valid) begin
      busy_eff[wb_rd] = 1'b0;
    end
    hazard = check_en && ((rs1_used && busy_eff[rs1]) ||
                          (rs2_used && busy_eff[rs2]));
  end

  // Set is applied after clear so a same-register set/clear leaves it busy.
  always_comb begin
    busy_d = busy_eff;
    if (set_en) begin
      busy_d[set_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/decode_alu_pipe.sv
// decode_alu_pipe: registered decode of RV32I ALU instructions (R-type and,
// optionally, I-type) with a one-entry valid/ready output register, a RAW
// scoreboard that stalls dependents until writeback, and a saturating
// stall-cycle counter.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready/instr         fetch-side handshake and instruction word
//   flush                           squash output register and scoreboard
//   out_valid/out_ready             execute-side handshake
//   out_rs1/out_rs2/out_rd          register indices (rs2 = 0 for I-type)
//   out_alu_control                 ALU op code (ALU_NOP when illegal)
//   out_imm/out_use_imm             sign-extended I-immediate and operand-B select
//   out_illegal                     unsupported encoding flag
//   wb_valid/wb_rd                  writeback retiring a register
//   stall_count                     saturating count of hazard-stall cycles
module decode_alu_pipe
  import decode_alu_pipe_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int ITYPE_EN = 1,
  parameter  int SB_EN    = 1,
  parameter  int CNT_W    = 16,
  localparam int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic [REG_W-1:0] out_rd,
  output logic [4:0]       out_alu_control,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_use_imm,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  output logic [CNT_W-1:0] stall_count
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  dec_t             dec;
  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic [REG_W-1:0] dec_rd;
  logic [XLEN-1:0]  dec_imm;

  logic hazard;
  logic accept;
  logic set_en;

  logic             valid_q,   valid_d;
  logic [REG_W-1:0] rs1_q,     rs1_d;
  logic [REG_W-1:0] rs2_q,     rs2_d;
  logic [REG_W-1:0] rd_q,      rd_d;
  logic [4:0]       alu_q,     alu_d;
  logic [XLEN-1:0]  imm_q,     imm_d;
  logic             use_imm_q, use_imm_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign dec_rs1 = REG_W'(instr[19:15]);
  assign dec_rd  = REG_W'(instr[11:7]);

  // Combinational decode. Anything not matched keeps the ALU_NOP/illegal
  // defaults; field extraction follows the opcode class regardless.
  always_comb begin
    dec.alu_control = ALU_NOP;
    dec.illegal     = 1'b1;
    dec.use_imm     = 1'b0;
    dec.is_r        = 1'b0;
    dec_rs2         = REG_W'(instr[24:20]);
    dec_imm         = '0;
    if (opcode == OP_R) begin
      dec.is_r    = 1'b1;
      dec.illegal = 1'b0;
      if (f7 == F7_BASE) begin
        case (f3)
          F3_ADD:  dec.alu_control = ALU_ADD;
          F3_SLL:  dec.alu_control = ALU_SLL;
          F3_SLT:  dec.alu_control = ALU_SLT;
          F3_SLTU: dec.alu_control = ALU_SLTU;
          F3_XOR:  dec.alu_control = ALU_XOR;
          F3_SR:   dec.alu_control = ALU_SRL;
          F3_OR:   dec.alu_control = ALU_OR;
          F3_AND:  dec.alu_control = ALU_AND;
          default: dec.illegal     = 1'b1;
        endcase
      end else if (f7 == F7_ALT && f3 == F3_ADD) begin
        dec.alu_control = ALU_SUB;
      end else if (f7 == F7_ALT && f3 == F3_SR) begin
        dec.alu_control = ALU_SRA;
      end else begin
        dec.illegal = 1'b1;
      end
    end else if (ITYPE_EN != 0 && opcode == OP_I) begin
      dec.use_imm = 1'b1;
      dec.illegal = 1'b0;
      dec_rs2     = '0;
      dec_imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
      case (f3)
        F3_ADD:  dec.alu_control = ALU_ADD;
        F3_SLT:  dec.alu_control = ALU_SLT;
        F3_SLTU: dec.alu_control = ALU_SLTU;
        F3_XOR:  dec.alu_control = ALU_XOR;
        F3_OR:   dec.alu_control = ALU_OR;
        F3_AND:  dec.alu_control = ALU_AND;
        // Shift-immediates share funct7 with R-type; shamt sits in [24:20].
        F3_SLL: begin
          if (f7 == F7_BASE) dec.alu_control = ALU_SLL;
          else               dec.illegal     = 1'b1;
        end
        F3_SR: begin
          if (f7 == F7_BASE)     dec.alu_control = ALU_SRL;
          else if (f7 == F7_ALT) dec.alu_control = ALU_SRA;
          else                   dec.illegal     = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    if (dec.illegal) begin
      dec.alu_control = ALU_NOP;
    end
  end

  generate
    if (SB_EN != 0) begin : g_sb
      alu_scoreboard #(
        .NUM_REGS(NUM_REGS),
        .REG_W   (REG_W)
      ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .check_en(in_valid),
        .rs1     (dec_rs1),
        .rs1_used(!dec.illegal),
        .rs2     (dec_rs2),
        .rs2_used(!dec.illegal && dec.is_r),
        .set_en  (set_en),
        .set_rd  (dec_rd),
        .wb_valid(wb_valid),
        .wb_rd   (wb_rd),
        .hazard  (hazard)
      );
    end else begin : g_no_sb
      assign hazard = 1'b0;
    end
  endgenerate

  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign set_en   = accept && !dec.illegal && (dec_rd != '0);

  // Output register: flush beats accept, accept beats consume.
  always_comb begin
    valid_d   = valid_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    alu_d     = alu_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      rs1_d     = dec_rs1;
      rs2_d     = dec_rs2;
      rd_d      = dec_rd;
      alu_d     = dec.alu_control;
      imm_d     = dec_imm;
      use_imm_d = dec.use_imm;
      illegal_d = dec.illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Stall counter sticks at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_q       <= ALU_NOP;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_rs1         = rs1_q;
  assign out_rs2         = rs2_q;
  assign out_rd          = rd_q;
  assign out_alu_control = alu_q;
  assign out_imm         = imm_q;
  assign out_use_imm     = use_imm_q;
  assign out_illegal     = illegal_q;
  assign stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_decode_alu_pipe.sv
// Bench for decode_alu_pipe: table of decode vectors, hand-written hazard,
// backpressure, flush and saturation sequences, then randomized traffic
// compared every cycle against a behavioural model.
module tb_decode_alu_pipe;
  import decode_alu_pipe_pkg::*;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, flush;
  logic             out_valid, out_ready, out_use_imm, out_illegal, wb_valid;
  logic [31:0]      instr;
  logic [REG_W-1:0] out_rs1, out_rs2, out_rd, wb_rd;
  logic [4:0]       out_alu_control;
  logic [XLEN-1:0]  out_imm;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  decode_alu_pipe #(
    .XLEN(XLEN), .NUM_REGS(32), .ITYPE_EN(1), .SB_EN(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_alu_control(out_alu_control), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_count(stall_count)
  );

  int n_vec = 0;
  int n_err = 0;
  bit last_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal encodings listed as (opcode, funct3, funct7, funct7-checked, code).
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         f7_care;
    logic [4:0] code;
  } pat_t;
  pat_t pats[$];

  function automatic void mdecode(input logic [31:0] w, output logic [4:0] code,
                                  output bit ill, output bit is_i, output bit is_r);
    code = ALU_NOP;
    ill  = 1'b1;
    is_r = (w[6:0] == 7'h33);
    is_i = (w[6:0] == 7'h13);
    foreach (pats[k]) begin
      if (pats[k].op == w[6:0] && pats[k].f3 == w[14:12] &&
          (!pats[k].f7_care || pats[k].f7 == w[31:25])) begin
        code = pats[k].code;
        ill  = 1'b0;
      end
    end
  endfunction

  // Behavioural model state.
  bit         m_ov, m_use, m_ill;
  logic [4:0] m_rs1, m_rs2, m_rd, m_alu;
  logic [31:0] m_imm;
  bit         m_busy[32];
  int         m_cnt;

  function automatic void model_reset();
    m_ov = 0; m_use = 0; m_ill = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_alu = ALU_NOP; m_imm = 0; m_cnt = 0;
    foreach (m_busy[r]) m_busy[r] = 0;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, m_ov);
    chk("out_rs1", out_rs1, m_rs1);
    chk("out_rs2", out_rs2, m_rs2);
    chk("out_rd", out_rd, m_rd);
    chk("out_alu_control", out_alu_control, m_alu);
    chk("out_imm", out_imm, m_imm);
    chk("out_use_imm", out_use_imm, m_use);
    chk("out_illegal", out_illegal, m_ill);
    chk("stall_count", stall_count, m_cnt);
  endtask

  // One clock: drive inputs, check in_ready before the edge, advance the
  // model, check registered outputs after the edge. Entered at posedge+1.
  task automatic cyc(input bit v, input logic [31:0] w, input bit ordy,
                     input bit fl, input bit wv, input logic [4:0] wr);
    logic [4:0] code;
    bit ill, is_i, is_r, hz, rdy, acc;
    bit beff[32];
    in_valid = v; instr = w; out_ready = ordy; flush = fl; wb_valid = wv; wb_rd = wr;
    mdecode(w, code, ill, is_i, is_r);
    for (int r = 0; r < 32; r++) beff[r] = m_busy[r] && !(wv && wr == r);
    hz  = v && !ill && (beff[w[19:15]] || (is_r && beff[w[24:20]]));
    rdy = (!m_ov || ordy) && !hz && !fl;
    acc = v && rdy;
    #2;
    last_rdy = in_ready;
    chk("in_ready", in_ready, rdy);
    if (v && hz && m_cnt != CNT_MAX) m_cnt++;
    if (fl) begin
      foreach (m_busy[r]) m_busy[r] = 0;
    end else begin
      if (wv) m_busy[wr] = 0;
      if (acc && !ill && w[11:7] != 0) m_busy[w[11:7]] = 1;
    end
    if (fl) m_ov = 0;
    else if (acc) begin
      m_ov  = 1;
      m_rs1 = w[19:15];
      m_rd  = w[11:7];
      m_alu = code;
      m_ill = ill;
      if (is_i) begin
        m_rs2 = 0; m_imm = {{20{w[31]}}, w[31:20]}; m_use = 1;
      end else begin
        m_rs2 = w[24:20]; m_imm = 0; m_use = 0;
      end
    end else if (ordy) m_ov = 0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Reset leaves the other inputs as they are (reset may land mid-stall).
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_alu_control", out_alu_control, ALU_NOP);
    chk("rst out_rd", out_rd, 5'd0);
    chk("rst out_imm", out_imm, 32'd0);
    chk("rst out_illegal", out_illegal, 1'b0);
    chk("rst stall_count", stall_count, 8'd0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  alu;
    logic        ill;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
  } vec_t;
  vec_t tbl[14];

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB   = 32'h40118233; // sub  x4,x3,x1
  localparam logic [31:0] I_ADDI6 = 32'h00500313; // addi x6,x0,5
  localparam logic [31:0] I_BADSL = 32'h40009093; // slli with funct7 0100000
  localparam logic [31:0] I_ADDX1 = 32'h00008133; // add  x2,x1,x0
  localparam logic [31:0] I_SETX5 = 32'h00100293; // addi x5,x0,1
  localparam logic [31:0] I_DEPX5 = 32'h00028313; // addi x6,x5,0

  initial begin
    pats.push_back('{7'h33, 3'b000, 7'h00, 1, ALU_ADD});
    pats.push_back('{7'h33, 3'b000, 7'h20, 1, ALU_SUB});
    pats.push_back('{7'h33, 3'b001, 7'h00, 1, ALU_SLL});
    pats.push_back('{7'h33, 3'b010, 7'h00, 1, ALU_SLT});
    pats.push_back('{7'h33, 3'b011, 7'h00, 1, ALU_SLTU});
    pats.push_back('{7'h33, 3'b100, 7'h00, 1, ALU_XOR});
    pats.push_back('{7'h33, 3'b101, 7'h00, 1, ALU_SRL});
    pats.push_back('{7'h33, 3'b101, 7'h20, 1, ALU_SRA});
    pats.push_back('{7'h33, 3'b110, 7'h00, 1, ALU_OR});
    pats.push_back('{7'h33, 3'b111, 7'h00, 1, ALU_AND});
    pats.push_back('{7'h13, 3'b000, 7'h00, 0, ALU_ADD});
    pats.push_back('{7'h13, 3'b010, 7'h00, 0, ALU_SLT});
    pats.push_back('{7'h13, 3'b011, 7'h00, 0, ALU_SLTU});
    pats.push_back('{7'h13, 3'b100, 7'h00, 0, ALU_XOR});
    pats.push_back('{7'h13, 3'b110, 7'h00, 0, ALU_OR});
    pats.push_back('{7'h13, 3'b111, 7'h00, 0, ALU_AND});
    pats.push_back('{7'h13, 3'b001, 7'h00, 1, ALU_SLL});
    pats.push_back('{7'h13, 3'b101, 7'h00, 1, ALU_SRL});
    pats.push_back('{7'h13, 3'b101, 7'h20, 1, ALU_SRA});

    //            instr         alu       ill use imm           rs1 rs2 rd
    tbl[0]  = '{32'h002081B3, ALU_ADD,  0, 0, 32'h0,        1,  2,  3};
    tbl[1]  = '{32'hFFF0C093, ALU_XOR,  0, 1, 32'hFFFFFFFF, 1,  0,  1};
    tbl[2]  = '{32'h40118233, ALU_SUB,  0, 0, 32'h0,        3,  1,  4};
    tbl[3]  = '{32'h4000D093, ALU_SRA,  0, 1, 32'h00000400, 1,  0,  1};
    tbl[4]  = '{32'h40009093, ALU_NOP,  1, 1, 32'h00000400, 1,  0,  1};
    tbl[5]  = '{32'h0000006F, ALU_NOP,  1, 0, 32'h0,        0,  0,  0};
    tbl[6]  = '{32'h007332B3, ALU_SLTU, 0, 0, 32'h0,        6,  7,  5};
    tbl[7]  = '{32'h407352B3, ALU_SRA,  0, 0, 32'h0,        6,  7,  5};
    tbl[8]  = '{32'hFFB1A113, ALU_SLT,  0, 1, 32'hFFFFFFFB, 3,  0,  2};
    tbl[9]  = '{32'h7FF47393, ALU_AND,  0, 1, 32'h000007FF, 8,  0,  7};
    tbl[10] = '{32'h02208033, ALU_NOP,  1, 0, 32'h0,        1,  2,  0};
    tbl[11] = '{32'h003150B3, ALU_SRL,  0, 0, 32'h0,        2,  3,  1};
    tbl[12] = '{32'h01F51493, ALU_SLL,  0, 1, 32'h0000001F, 10, 0,  9};
    tbl[13] = '{32'h40209033, ALU_NOP,  1, 0, 32'h0,        1,  2,  0};

    in_valid = 0; instr = 0; out_ready = 0; flush = 0; wb_valid = 0; wb_rd = 0;
    do_reset();

    // Decode table: each vector after a flush so nothing is busy.
    for (int i = 0; i < 14; i++) begin
      cyc(0, 32'h0, 1, 1, 0, 0);
      cyc(1, tbl[i].instr, 1, 0, 0, 0);
      chk("tbl accepted", last_rdy, 1'b1);
      chk("tbl alu_control", out_alu_control, tbl[i].alu);
      chk("tbl illegal", out_illegal, tbl[i].ill);
      chk("tbl use_imm", out_use_imm, tbl[i].use_imm);
      chk("tbl imm", out_imm, tbl[i].imm);
      chk("tbl rs1", out_rs1, tbl[i].rs1);
      chk("tbl rs2", out_rs2, tbl[i].rs2);
      chk("tbl rd", out_rd, tbl[i].rd);
    end

    // RAW hazard on x3, released by a same-cycle writeback.
    in_valid = 0; out_ready = 0; flush = 0; wb_valid = 0;
    do_reset();
    cyc(1, I_ADD, 1, 0, 0, 0);
    chk("add valid", out_valid, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, I_SUB, 1, 0, 0, 0);
      chk("sub stalled", last_rdy, 1'b0);
      chk("stall_count step", stall_count, k[CNT_W-1:0]);
    end
    cyc(1, I_SUB, 1, 0, 1, 5'd3);
    chk("sub released by wb", last_rdy, 1'b1);
    chk("sub alu", out_alu_control, ALU_SUB);
    chk("sub rd", out_rd, 5'd4);

    // Backpressure: output holds, then consume and accept together.
    cyc(1, I_ADDI6, 0, 0, 0, 0);
    chk("bp in_ready", last_rdy, 1'b0);
    chk("bp hold rd", out_rd, 5'd4);
    cyc(1, I_ADDI6, 0, 0, 0, 0);
    chk("bp hold alu", out_alu_control, ALU_SUB);
    cyc(1, I_ADDI6, 1, 0, 0, 0);
    chk("bp accept", last_rdy, 1'b1);
    chk("bp new rd", out_rd, 5'd6);
    chk("bp new imm", out_imm, 32'd5);

    // Illegal instruction does not mark its rd (x1) busy.
    cyc(1, I_BADSL, 1, 0, 0, 0);
    chk("bad slli illegal", out_illegal, 1'b1);
    cyc(1, I_ADDX1, 1, 0, 0, 0);
    chk("x1 not busy", last_rdy, 1'b1);

    // Flush clears the scoreboard; the dependent issues right after.
    cyc(1, I_SETX5, 1, 0, 0, 0);
    cyc(1, I_DEPX5, 1, 0, 0, 0);
    chk("dep x5 stalled", last_rdy, 1'b0);
    cyc(0, 32'h0, 1, 1, 1, 5'd7);
    chk("flush out_valid", out_valid, 1'b0);
    cyc(1, I_DEPX5, 1, 0, 0, 0);
    chk("dep x5 after flush", last_rdy, 1'b1);
    chk("dep x5 rd", out_rd, 5'd6);

    // Saturation: 2^CNT_W + 3 stall cycles.
    in_valid = 0; flush = 0; wb_valid = 0;
    do_reset();
    cyc(1, I_SETX5, 1, 0, 0, 0);
    for (int k = 0; k < CNT_MAX + 4; k++) cyc(1, I_DEPX5, 1, 0, 0, 0);
    chk("stall saturated", stall_count, CNT_MAX[CNT_W-1:0]);
    chk("still stalled", last_rdy, 1'b0);

    // Reset mid-stall returns everything to the reset state.
    do_reset();
    cyc(1, I_DEPX5, 1, 0, 0, 0);
    chk("dep after reset", last_rdy, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] w;
      logic [6:0]  f7;
      int          k;
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: f7 = 7'h20;
        1: f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      if (k < 8) begin
        w = {f7, 2'b00, 3'($urandom), 2'b00, 3'($urandom), 3'($urandom),
             2'b00, 3'($urandom), (k < 4) ? 7'h33 : 7'h13};
      end else begin
        w = $urandom;
      end
      cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 4) < 2,
          5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
